// File: rtl/perm_pkg.sv
// rtl/perm_pkg.sv - shared types and constants for the Keccak-f[1600] permutation control
package perm_pkg;

  localparam int NROUNDS_DEF = 24;
  localparam int NCHUNKS_DEF = 8;
  localparam int CHUNK_W     = 200;
  localparam int LANE_W      = 64;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    UNLOAD
  } seq_state_e;

  typedef logic [LANE_W-1:0]  lane_t;
  typedef lane_t [4:0][4:0]   state_t;
  typedef logic [CHUNK_W-1:0] chunk_t;

endpackage

// File: rtl/perm_round_seq_if.sv
// rtl/perm_round_seq_if.sv - sequencer handshake bundle; PERM_ROUND_SEQ_ABORT_EN adds abort
interface perm_round_seq_if;
  logic       pushin;
  logic [2:0] dix;
  logic       in_ready;
  logic       load_en;
  logic       sel_din;
  logic       round_en;
  logic [4:0] round_idx;
  logic       pushout;
  logic [2:0] doutix;
  logic       busy;
  logic       err_order;
`ifdef PERM_ROUND_SEQ_ABORT_EN
  logic       abort;

  modport master (
    input  pushin, dix, abort,
    output in_ready, load_en, sel_din, round_en, round_idx,
           pushout, doutix, busy, err_order
  );
  modport slave (
    output pushin, dix, abort,
    input  in_ready, load_en, sel_din, round_en, round_idx,
           pushout, doutix, busy, err_order
  );
`else
  modport master (
    input  pushin, dix,
    output in_ready, load_en, sel_din, round_en, round_idx,
           pushout, doutix, busy, err_order
  );
  modport slave (
    output pushin, dix,
    input  in_ready, load_en, sel_din, round_en, round_idx,
           pushout, doutix, busy, err_order
  );
`endif
endinterface

// File: rtl/perm_mod_cnt.sv
// rtl/perm_mod_cnt.sv - modulo counter with synchronous clear, enable, step and terminal flag
module perm_mod_cnt #(
  parameter int MOD  = 8,
  parameter int STEP = 1,
  parameter int W    = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         last
);
  localparam logic [W-1:0] LAST_Q = W'(MOD - STEP);

  assign last = (q == LAST_Q);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= last ? '0 : q + W'(STEP);
    end
  end
endmodule

// File: rtl/perm_round_seq.sv
// rtl/perm_round_seq.sv - Keccak-f[1600] load/run/unload sequencer; PERM_ROUND_SEQ_ABORT_EN adds abort input
module perm_round_seq
  import perm_pkg::*;
#(
  parameter int NROUNDS = NROUNDS_DEF,
  parameter int NCHUNKS = NCHUNKS_DEF,
  parameter int RPC     = 1
) (
  input logic              clk,
  input logic              reset,
  perm_round_seq_if.master bus
);
  seq_state_e state, state_n;
  logic       abort;
  logic [2:0] exp_q, unl_q;
  logic [4:0] rnd_q;
  logic       exp_last, rnd_last, unl_last;
  logic       accept, mis_order, block_done;
  logic       sel_din_q, round_en_q, pushout_q, busy_q, err_order_q;

`ifdef PERM_ROUND_SEQ_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif

  assign bus.in_ready = (state == LOAD);
  assign accept       = bus.in_ready && bus.pushin && (bus.dix == exp_q);
  assign mis_order    = bus.in_ready && bus.pushin && (bus.dix != exp_q);
  assign block_done   = accept && exp_last;
  assign bus.load_en  = accept;

  perm_mod_cnt #(.MOD(NCHUNKS), .STEP(1), .W(3)) u_exp_cnt (
    .clk  (clk),
    .clr  (reset || abort),
    .en   (accept),
    .q    (exp_q),
    .last (exp_last)
  );

  // Round counter holds on its terminal value so round_idx keeps its last value outside RUN.
  perm_mod_cnt #(.MOD(NROUNDS), .STEP(RPC), .W(5)) u_rnd_cnt (
    .clk  (clk),
    .clr  (reset || abort || block_done),
    .en   ((state == RUN) && !rnd_last),
    .q    (rnd_q),
    .last (rnd_last)
  );

  perm_mod_cnt #(.MOD(NCHUNKS), .STEP(1), .W(3)) u_unl_cnt (
    .clk  (clk),
    .clr  (reset || abort),
    .en   (state == UNLOAD),
    .q    (unl_q),
    .last (unl_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD:    if (block_done) state_n = RUN;
      RUN:     if (rnd_last)   state_n = UNLOAD;
      UNLOAD:  if (unl_last)   state_n = LOAD;
      default:                 state_n = LOAD;
    endcase
    if (abort) begin
      state_n = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_din_q   <= 1'b0;
      round_en_q  <= 1'b0;
      pushout_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_order_q <= 1'b0;
    end else begin
      sel_din_q   <= (state == LOAD) && (state_n == RUN);
      round_en_q  <= (state_n == RUN);
      pushout_q   <= (state_n == UNLOAD);
      busy_q      <= (state_n != LOAD);
      err_order_q <= err_order_q || mis_order;
    end
  end

  assign bus.sel_din   = sel_din_q;
  assign bus.round_en  = round_en_q;
  assign bus.round_idx = rnd_q;
  assign bus.pushout   = pushout_q;
  assign bus.doutix    = unl_q;
  assign bus.busy      = busy_q;
  assign bus.err_order = err_order_q;
endmodule

// File: doc/perm_round_seq.md
Name: perm_round_seq

Overview:
- Control sequencer for the Keccak-f[1600] permutation datapath.
- Accepts eight 200-bit input chunks in order (dix 0..7), then steps the round logic through all rounds, then emits eight output chunks.
- Drives load enables, the data-select and state-register enables, the round index for the iota constant, and the output chunk index/push.
- Sits between the input interface, the round logic and the output stage.

Parameters:
NROUNDS, 24, number of permutation rounds.
NCHUNKS, 8, number of 200-bit chunks per 1600-bit state.
RPC, 1, rounds computed per clock; must divide NROUNDS (legal values 1, 2, 3, 4).

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
pushin  in  1  input chunk valid.
dix  in  3  index of the input chunk.
in_ready  out  1  high in LOAD state only.
load_en  out  1  pushin && in_ready && (dix == expected index); write strobe to the input interface.
sel_din  out  1  high on the first RUN cycle; round logic takes loaded data instead of the recirculated state.
round_en  out  1  high on every RUN cycle; enables the state register.
round_idx  out  5  index of the first round computed this cycle (0, RPC, 2·RPC, …).
pushout  out  1  output chunk valid.
doutix  out  3  index of the output chunk.
busy  out  1  high in RUN or UNLOAD.
err_order  out  1  sticky flag: an out-of-order chunk was seen.

Behaviour:
- Reset (synchronous, active-high; clk and reset fixed as the codebase names them):
  - state = LOAD; expected index = 0; round counter = 0; unload counter = 0.
  - All outputs 0 except in_ready = 1.
  - Reset mid-operation aborts immediately with no further pushout.
- LOAD:
  - A chunk with pushin=1 and dix==expected is accepted: load_en=1 (combinational), expected index increments.
  - pushin=1 with dix!=expected: chunk dropped, load_en=0, err_order set (stays set until reset), expected index unchanged.
  - Acceptance of chunk NCHUNKS-1: next state RUN, expected index wraps to 0.
- RUN:
  - Lasts NROUNDS/RPC cycles; round_en=1 every cycle; sel_din=1 only on the first.
  - round_idx starts at 0 and advances by RPC each cycle.
  - On the cycle with round_idx == NROUNDS-RPC: next state UNLOAD.
  - pushin is ignored (in_ready=0); it does not set err_order.
- UNLOAD:
  - pushout=1 for NCHUNKS consecutive cycles, doutix = 0..NCHUNKS-1. There is no backpressure.
  - After doutix == NCHUNKS-1: next state LOAD.
- Latency:
  - First pushout occurs NROUNDS/RPC + 1 cycles after the edge that accepts chunk 7. This is 25 cycles at the defaults.
  - Full block turnaround, from the accept of chunk 7 to the next in_ready, is NROUNDS/RPC + NCHUNKS + 1 cycles.
- round_idx holds its last value outside RUN; it is 0 after reset.
- All outputs are registered except in_ready and load_en, which are combinational from the state and inputs.

Optional Feature:
PERM_ROUND_SEQ_ABORT_EN:
- Defined: adds input port abort (1 bit).
  - abort=1 in RUN or UNLOAD: next state LOAD with counters cleared; no pushout on or after that edge.
  - abort=1 in LOAD: clears the expected index to 0.
  - abort has priority over all transitions except reset.
- Undefined: the port does not exist and the behaviour is exactly as above.

Decomposition:
- Package perm_pkg:
  - state enum {LOAD, RUN, UNLOAD}.
  - Constants NROUNDS_DEF=24, NCHUNKS_DEF=8, CHUNK_W=200, LANE_W=64.
  - typedef lane_t = logic[63:0]; typedef state_t = lane_t [4:0][4:0].
- One sub-module, perm_mod_cnt:
  - Parameterised modulo counter with clear, enable, step and terminal flag.
  - Instantiated for the expected index, the round counter and the unload counter.

Test Plan:
- Reset, then dix 0..7 with pushin every cycle:
  - load_en high for 8 cycles.
  - sel_din=1 on the next cycle; round_idx runs 0..23 over 24 cycles.
  - pushout doutix 0..7 starting 25 cycles after chunk 7; then in_ready=1.
- Out-of-order load, chunks 0, 1, then 3: load_en=0 for the 3 and err_order=1; sending 2 then 3..7 completes normally with err_order still 1.
- pushin with dix=0 during RUN at round_idx=10: ignored, round_idx continues to 11, err_order stays 0.
- Reset asserted at the 3rd UNLOAD cycle (doutix=2): pushout=0 on the next cycle, state LOAD, round_idx=0.
- RPC=4: RUN lasts 6 cycles with round_idx 0, 4, 8, 12, 16, 20; first pushout 7 cycles after chunk 7.
- ABORT_EN: abort at round_idx=5: next cycle in_ready=1, busy=0, and no pushout follows.
